// File: rtl/divider_ctrl.sv
// rtl/divider_ctrl.sv - programmable duty-cycle clock divider with period-aligned start/stop and reconfiguration
module divider_ctrl #(
  parameter int W        = 8,
  parameter int DEF_DIV  = 6,
  parameter int DEF_HIGH = 3,
  parameter int PCNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [W-1:0]      cfg_div,
  input  logic [W-1:0]      cfg_high,
  output logic              cfg_err,
  output logic              div_out,
  output logic              period_tick,
  output logic              running,
  output logic [PCNT_W-1:0] period_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, STOP_PEND} state_t;

  state_t       state;
  logic [W-1:0] act_div;
  logic [W-1:0] act_high;
  logic [W-1:0] shd_div;
  logic [W-1:0] shd_high;
  logic         shd_valid;
  logic [W-1:0] cnt;

  logic         accept;
  logic         legal;
  logic         wrap;
  logic         go;
  logic [W-1:0] cnt_n;

  always_comb begin
    accept = cfg_valid && cfg_ready;
    legal  = (cfg_div >= W'(2)) && (cfg_high != '0) && (cfg_high < cfg_div);
    wrap   = (cnt == act_div - W'(1));
    cnt_n  = wrap ? '0 : cnt + W'(1);
    go     = start && !stop;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      act_div     <= W'(DEF_DIV);
      act_high    <= W'(DEF_HIGH);
      shd_div     <= '0;
      shd_high    <= '0;
      shd_valid   <= 1'b0;
      cnt         <= '0;
      cfg_ready   <= 1'b1;
      cfg_err     <= 1'b0;
      div_out     <= 1'b0;
      period_tick <= 1'b0;
      running     <= 1'b0;
      period_cnt  <= '0;
    end else begin
      cfg_err     <= accept && !legal;
      period_tick <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && legal) begin
            act_div  <= cfg_div;
            act_high <= cfg_high;
          end
          if (go) begin
            state       <= RUN;
            running     <= 1'b1;
            cnt         <= '0;
            div_out     <= 1'b1;
            period_tick <= 1'b1;
          end
        end
        RUN, STOP_PEND: begin
          cnt         <= cnt_n;
          div_out     <= (cnt_n < act_high);
          period_tick <= wrap;
          // shadow holds a config while a period is in flight; cfg_ready low blocks overwrite
          if (accept && legal) begin
            shd_div   <= cfg_div;
            shd_high  <= cfg_high;
            shd_valid <= 1'b1;
            cfg_ready <= 1'b0;
          end
          if (wrap) begin
            period_cnt <= period_cnt + PCNT_W'(1);
            if (shd_valid) begin
              act_div   <= shd_div;
              act_high  <= shd_high;
              shd_valid <= 1'b0;
              cfg_ready <= 1'b1;
            end
          end
          if (state == RUN) begin
            if (stop) state <= STOP_PEND;
          end else if (go) begin
            state <= RUN;
          end else if (wrap) begin
            state       <= IDLE;
            running     <= 1'b0;
            cnt         <= '0;
            div_out     <= 1'b0;
            period_tick <= 1'b0;
            // a config taken on the final edge lands directly since we are now idle
            if (accept && legal) begin
              act_div   <= cfg_div;
              act_high  <= cfg_high;
              shd_valid <= 1'b0;
              cfg_ready <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_ctrl.sv
// tb/tb_divider_ctrl.sv - directed self-checking bench for divider_ctrl
module tb_divider_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, stop, cfg_valid;
  logic [7:0] cfg_div, cfg_high;
  logic       cfg_ready, cfg_err, div_out, period_tick, running;
  logic [15:0] period_cnt;
  logic       cfg_ready4, cfg_err4, div_out4, period_tick4, running4;
  logic [3:0] period_cnt4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  divider_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_div(cfg_div), .cfg_high(cfg_high),
    .cfg_err(cfg_err), .div_out(div_out), .period_tick(period_tick),
    .running(running), .period_cnt(period_cnt)
  );

  divider_ctrl #(.PCNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready4), .cfg_div(cfg_div), .cfg_high(cfg_high),
    .cfg_err(cfg_err4), .div_out(div_out4), .period_tick(period_tick4),
    .running(running4), .period_cnt(period_cnt4)
  );

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic out3(input string tag, input int d, input int t, input int r);
    chk({tag, ".div"}, div_out, d);
    chk({tag, ".tick"}, period_tick, t);
    chk({tag, ".run"}, running, r);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; cfg_valid = 1'b0; cfg_div = 8'd0; cfg_high = 8'd0;
    step(); step();
    reset = 1'b0;
    chk("rst.div", div_out, 0);
    chk("rst.tick", period_tick, 0);
    chk("rst.err", cfg_err, 0);
    chk("rst.run", running, 0);
    chk("rst.ready", cfg_ready, 1);
    chk("rst.pcnt", period_cnt, 0);

    // defaults 6/3
    start = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      out3("def", ((i % 6) < 3) ? 1 : 0, ((i % 6) == 0) ? 1 : 0, 1);
      chk("def.pcnt", period_cnt, i / 6);
    end
    start = 1'b0;

    // reconfigure to 4/1 mid-period (cnt=2)
    step(); step(); step();
    cfg_valid = 1'b1; cfg_div = 8'd4; cfg_high = 8'd1;
    step();
    cfg_valid = 1'b0;
    chk("cfg.ready_c3", cfg_ready, 0);
    chk("cfg.div_c3", div_out, 0);
    step(); step();
    chk("cfg.ready_c5", cfg_ready, 0);
    step();
    chk("cfg.ready_apply", cfg_ready, 1);
    out3("cfg.c0", 1, 1, 1);
    for (int j = 1; j <= 7; j++) begin
      step();
      out3("n4", (j % 4 == 0) ? 1 : 0, (j % 4 == 0) ? 1 : 0, 1);
    end
    // pend a 3/2 shadow, then reset in the high phase
    cfg_valid = 1'b1; cfg_div = 8'd3; cfg_high = 8'd2;
    step();
    cfg_valid = 1'b0;
    out3("pend.c0", 1, 1, 1);
    chk("pend.ready", cfg_ready, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    out3("rst2", 0, 0, 0);
    chk("rst2.pcnt", period_cnt, 0);
    chk("rst2.ready", cfg_ready, 1);

    // illegal configs in IDLE
    cfg_valid = 1'b1; cfg_div = 8'd1; cfg_high = 8'd0;
    step();
    chk("ill1.err", cfg_err, 1);
    chk("ill1.ready", cfg_ready, 1);
    cfg_div = 8'd5; cfg_high = 8'd5;
    step();
    chk("ill2.err", cfg_err, 1);
    cfg_valid = 1'b0;
    step();
    chk("ill.err_clr", cfg_err, 0);

    // must run 6/3: defaults restored, shadow and illegal configs gone
    start = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      out3("post", ((i % 6) < 3) ? 1 : 0, ((i % 6) == 0) ? 1 : 0, 1);
    end
    start = 1'b0;

    // stop at cnt=2 completes the period
    step(); step(); step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    out3("stop.c3", 0, 0, 1);
    step(); step();
    out3("stop.c5", 0, 0, 1);
    step();
    out3("stop.idle", 0, 0, 0);
    step();
    out3("stop.idle2", 0, 0, 0);
    start = 1'b1; stop = 1'b1;
    step();
    out3("both.idle", 0, 0, 0);
    stop = 1'b0;

    // cancel a pending stop
    step();
    start = 1'b0;
    out3("cancel.c0", 1, 1, 1);
    step(); step();
    stop = 1'b1;
    step();
    stop = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    out3("cancel.c4", 0, 0, 1);
    step();
    out3("cancel.c5", 0, 0, 1);
    step();
    out3("cancel.c0b", 1, 1, 1);
    step();
    out3("cancel.c1b", 1, 0, 1);

    // period counter wrap on the 4-bit instance with N=2 H=1
    reset = 1'b1;
    step();
    reset = 1'b0;
    cfg_valid = 1'b1; cfg_div = 8'd2; cfg_high = 8'd1; start = 1'b1;
    step();
    cfg_valid = 1'b0; start = 1'b0;
    chk("wrap.div0", div_out4, 1);
    chk("wrap.pc0", period_cnt4, 0);
    for (int s = 1; s <= 34; s++) begin
      step();
      chk("wrap.div", div_out4, (s % 2 == 0) ? 1 : 0);
      chk("wrap.pc", period_cnt4, (s / 2) % 16);
    end
    chk("wrap.pc16", period_cnt, 17);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
